spi_frame_receiver: RTL and testbench
=====================================

SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sclk_in, ncs_in and copi_in; legal range 2..3.
REQ-002 SHALL have parameter FRAME_BITS, default 16: bits per valid frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2: number of output frame buffer entries, power of two.
REQ-004 SHALL have port clk, input, 1: sole clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port sclk_in, input, 1: raw SPI clock, asynchronous to clk, mode 0.
REQ-007 SHALL have port ncs_in, input, 1: raw active-low chip select, asynchronous to clk.
REQ-008 SHALL have port copi_in, input, 1: raw controller-out data, asynchronous to clk.
REQ-009 SHALL have port frame_data, output, FRAME_BITS: head-of-FIFO frame, MSB = first bit received.
REQ-010 SHALL have port frame_valid, output, 1: frame_data is valid.
REQ-011 SHALL have port frame_ready, input, 1: downstream register decoder accepts the frame.
REQ-012 SHALL have port overflow, output, 1: sticky flag, a good frame was dropped because the FIFO was full.
REQ-013 SHALL have port err_cnt, output, 8: malformed-frame count; present only with SPI_ERR_CNT_EN.

Function
REQ-014 SHALL pass each raw input through SYNC_STAGES flops before use; the design SHALL use no raw input elsewhere.
REQ-015 SHALL detect an SCLK rise as sync sclk high in this cycle and low in the previous cycle; an nCS fall and an nCS rise SHALL use the same edge detection.
REQ-016 SHALL implement the FSM IDLE -> SHIFT on nCS fall, SHIFT -> CHECK on nCS rise, and CHECK -> IDLE after exactly one cycle.
REQ-017 In SHIFT, each SCLK rise SHALL shift sync copi into the LSB of the shift register, MSB first, and increment a saturating bit counter.
REQ-018 SHALL ignore SCLK rises in IDLE and CHECK.
REQ-019 In CHECK, a count equal to FRAME_BITS SHALL push the shift register into the FIFO; any other count, including 0, SHALL discard the frame and count as malformed.
REQ-020 SHALL clear the bit counter on entry to SHIFT.
REQ-021 SHALL handle an nCS fall in CHECK by entering SHIFT directly instead of IDLE, with no frame lost.
REQ-022 SHALL transfer a frame when frame_valid and frame_ready are both high on the same clk edge; frame_data SHALL hold stable while frame_valid is high and frame_ready is low.
REQ-023 SHALL assert frame_valid on the cycle after the CHECK cycle when the FIFO was empty, giving a latency of 1 clk from CHECK.
REQ-024 SHALL drop a push when the FIFO is full with no pop in the same cycle, and SHALL set overflow, which stays set until reset.
REQ-025 SHALL complete both a push and a pop to a full FIFO in the same cycle, with no overflow.
REQ-026 SHALL implement FIFO pointers with one extra wrap bit; full SHALL be pointer difference equal to FIFO_DEPTH.

Reset
REQ-027 SHALL force, on rst, the synchronizer flops to 0/1/0 for sclk/ncs/copi so that no edge is seen after release.
REQ-028 SHALL force, on rst, the FSM to IDLE; the counter, shift register, FIFO pointers, frame_data, frame_valid, overflow and err_cnt SHALL all be 0.
REQ-029 SHALL abort an in-flight frame when rst is asserted mid-frame; after release, the first nCS rise SHALL NOT push a partial frame, because the FSM is in IDLE.

Configuration
REQ-030 With SPI_ERR_CNT_EN defined, SHALL increment err_cnt by 1 per malformed frame in CHECK, saturating at 8'hFF.
REQ-031 Without SPI_ERR_CNT_EN, SHALL omit the err_cnt port and its counter; all other behaviour SHALL be identical.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, SHIFT, CHECK) and the default FRAME_BITS constant in the shared package spi_pkg.
REQ-033 SHALL implement the buffer as the sub-module frame_fifo, parameterized by width and depth, with a valid/ready interface on both sides.

Verification
REQ-034 Bench SHALL drive one 16-bit frame 16'hA55A with frame_ready=1 -> one frame_valid pulse, frame_data=16'hA55A, overflow=0.
REQ-035 Bench SHALL drive a 15-bit frame, then a 17-bit frame -> no frame_valid; err_cnt=2 with SPI_ERR_CNT_EN.
REQ-036 Bench SHALL drive 16'h0001, 16'h0002 and 16'h0003 with frame_ready=0 -> FIFO holds 0001 and 0002, overflow=1; then raise frame_ready -> 0001 then 0002 delivered in order.
REQ-037 Bench SHALL assert rst after 8 bits of a frame, release it, then send 16'h1234 -> only 16'h1234 delivered, err_cnt=0.
REQ-038 Bench SHALL drive back-to-back frames 16'hFFFF and 16'h0000 with a one-clk nCS-high gap -> both delivered, no error.
REQ-039 Bench SHALL hold the FIFO full with frame_ready=1 in the same cycle a new frame reaches CHECK -> push and pop both occur, overflow stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI frame receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } spi_state_t;

    localparam int DEFAULT_FRAME_BITS = 16;

endpackage

// File: rtl/frame_fifo.sv
// Small register FIFO with valid/ready on both sides; DEPTH must be a power of two >= 2.
module frame_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      used;
    logic             full;
    logic             push;
    logic             pop;

    assign used      = wr_ptr - rd_ptr;
    assign full      = (used == (AW + 1)'(DEPTH));
    assign out_valid = (used != '0);
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign pop       = out_valid && out_ready;
    // When full, the slot being written is the one being popped this cycle.
    assign in_ready  = !full || pop;
    assign push      = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= in_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 target that collects fixed-length frames into a small FIFO.
// Define SPI_ERR_CNT_EN to add the err_cnt malformed-frame counter port.
module spi_frame_receiver
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk_in,
    input  logic                  ncs_in,
    input  logic                  copi_in,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overflow
`ifdef SPI_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int CW = $clog2(FRAME_BITS + 2);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic                   sclk_s, ncs_s, copi_s;
    logic                   sclk_prev, ncs_prev;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    spi_state_t             state, state_next;
    logic [CW-1:0]          bit_cnt;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic                   push_req;
    logic                   bad_frame;
    logic                   fifo_in_ready;

    // Reset values mirror an idle bus so release never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            copi_sync <= '0;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_in};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_in};
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev;
    assign ncs_fall  = !ncs_s && ncs_prev;
    assign ncs_rise  = ncs_s && !ncs_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        bad_frame  = 1'b0;
        case (state)
            IDLE:  if (ncs_fall) state_next = SHIFT;
            SHIFT: if (ncs_rise) state_next = CHECK;
            CHECK: begin
                state_next = ncs_fall ? SHIFT : IDLE;
                push_req   = (bit_cnt == CW'(FRAME_BITS));
                bad_frame  = !push_req;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state != SHIFT && state_next == SHIFT) begin
            bit_cnt <= '0;
        end else if (state == SHIFT && sclk_rise) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
            if (bit_cnt != '1) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_req && !fifo_in_ready) begin
            overflow <= 1'b1;
        end
    end

`ifdef SPI_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (bad_frame && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_bad_frame;
    assign unused_bad_frame = bad_frame;
`endif

    frame_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push_req),
        .in_ready  (fifo_in_ready),
        .in_data   (shift_reg),
        .out_valid (frame_valid),
        .out_ready (frame_ready),
        .out_data  (frame_data)
    );

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver; define SPI_ERR_CNT_EN to also check err_cnt.
module tb_spi_frame_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk_in = 1'b0;
    logic        ncs_in = 1'b1;
    logic        copi_in = 1'b0;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        overflow;
`ifdef SPI_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] got [$];

    always #5 clk = ~clk;

    spi_frame_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .sclk_in     (sclk_in),
        .ncs_in      (ncs_in),
        .copi_in     (copi_in),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overflow    (overflow)
`ifdef SPI_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    // Inputs change at posedge+1, so the negedge sees what the next posedge will use.
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            got.push_back(frame_data);
        end
    end

    task automatic shift_bits(input logic [31:0] data, input int nbits);
        ncs_in = 1'b0;
        #40;
        for (int i = nbits - 1; i >= 0; i--) begin
            copi_in = data[i];
            #40 sclk_in = 1'b1;
            #40 sclk_in = 1'b0;
        end
        #40;
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits);
        shift_bits(data, nbits);
        ncs_in = 1'b1;
        #200;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst     = 1'b1;
        ncs_in  = 1'b1;
        sclk_in = 1'b0;
        copi_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %b want 0", frame_valid);
        end
        checks++;
        if (frame_data !== 16'h0000) begin
            errors++; $display("[TB] FAIL reset_data: got %h want 0000", frame_data);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow);
        end
`ifdef SPI_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
`endif
    endtask

    task automatic test_single_frame();
        frame_ready = 1'b1;
        got.delete();
        send_frame(32'h0000_A55A, 16);
        checks++;
        if (got.size() !== 1) begin
            errors++; $display("[TB] FAIL single_count: got %0d frames want 1", got.size());
        end else begin
            checks++;
            if (got[0] !== 16'hA55A) begin
                errors++; $display("[TB] FAIL single_data: got %h want a55a", got[0]);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL single_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_malformed();
        got.delete();
        send_frame(32'h0000_7FFF, 15);
        send_frame(32'h0001_2345, 17);
        checks++;
        if (got.size() !== 0) begin
            errors++; $display("[TB] FAIL malformed_delivered: got %0d frames want 0", got.size());
        end
`ifdef SPI_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++; $display("[TB] FAIL malformed_err_cnt: got %0d want 2", err_cnt);
        end
`endif
    endtask

    task automatic test_overflow();
        @(posedge clk); #1 frame_ready = 1'b0;
        got.delete();
        send_frame(32'h0000_0001, 16);
        send_frame(32'h0000_0002, 16);
        send_frame(32'h0000_0003, 16);
        checks++;
        if (frame_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL ovf_valid: got %b want 1", frame_valid);
        end
        checks++;
        if (frame_data !== 16'h0001) begin
            errors++; $display("[TB] FAIL ovf_head: got %h want 0001", frame_data);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow);
        end
        @(posedge clk); #1 frame_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got.size() !== 2) begin
            errors++; $display("[TB] FAIL ovf_count: got %0d frames want 2", got.size());
        end else begin
            checks++;
            if (got[0] !== 16'h0001) begin
                errors++; $display("[TB] FAIL ovf_first: got %h want 0001", got[0]);
            end
            checks++;
            if (got[1] !== 16'h0002) begin
                errors++; $display("[TB] FAIL ovf_second: got %h want 0002", got[1]);
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow);
        end
    endtask

    task automatic test_reset_midframe();
        got.delete();
        shift_bits(32'h0000_00FF, 8);
        apply_reset();
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_overflow: got %b want 0", overflow);
        end
        frame_ready = 1'b1;
        send_frame(32'h0000_1234, 16);
        checks++;
        if (got.size() !== 1 || got[0] !== 16'h1234) begin
            errors++; $display("[TB] FAIL midrst_frames: got %0d frames head %h want 1 frame 1234",
                               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
        end
`ifdef SPI_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++; $display("[TB] FAIL midrst_err_cnt: got %0d want 0", err_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        got.delete();
        shift_bits(32'h0000_FFFF, 16);
        ncs_in = 1'b1;
        #10;
        shift_bits(32'h0000_0000, 16);
        ncs_in = 1'b1;
        #200;
        checks++;
        if (got.size() !== 2) begin
            errors++; $display("[TB] FAIL b2b_count: got %0d frames want 2", got.size());
        end else begin
            checks++;
            if (got[0] !== 16'hFFFF || got[1] !== 16'h0000) begin
                errors++; $display("[TB] FAIL b2b_data: got %h %h want ffff 0000", got[0], got[1]);
            end
        end
`ifdef SPI_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++; $display("[TB] FAIL b2b_err_cnt: got %0d want 0", err_cnt);
        end
`endif
    endtask

    task automatic test_push_pop_full();
        @(posedge clk); #1 frame_ready = 1'b0;
        got.delete();
        send_frame(32'h0000_1111, 16);
        send_frame(32'h0000_2222, 16);
        shift_bits(32'h0000_3333, 16);
        ncs_in = 1'b1;
        // Two sync stages plus the edge register put CHECK on the fourth posedge.
        repeat (3) @(posedge clk);
        #1 frame_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL ppf_overflow: got %b want 0", overflow);
        end
        checks++;
        if (got.size() !== 3) begin
            errors++; $display("[TB] FAIL ppf_count: got %0d frames want 3", got.size());
        end else begin
            checks++;
            if (got[0] !== 16'h1111 || got[1] !== 16'h2222 || got[2] !== 16'h3333) begin
                errors++; $display("[TB] FAIL ppf_data: got %h %h %h want 1111 2222 3333",
                                   got[0], got[1], got[2]);
            end
        end
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL ppf_drained: got valid %b want 0", frame_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_malformed();
        test_overflow();
        test_reset_midframe();
        test_back_to_back();
        test_push_pop_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
